// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the multi-cycle data-memory controller:
// FSM encoding, default geometry/timeout and the bus-error fill word.
package data_memory_controller_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int COUNTER_WIDTH          = 16;

  localparam logic [31:0] BUS_ERROR_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmcState_e;

endpackage

// File: rtl/dmc_timeout_counter.sv
// Counts WAIT cycles without an acknowledge; terminal is high on the last
// cycle the controller may keep waiting (count == TIMEOUT_CYCLES-1).
module dmc_timeout_counter
  import data_memory_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [COUNTER_WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNTER_WIDTH'(1);
    end
  end

  assign terminal = (count == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage front end for a slow req/ack word memory; stalls the pipeline until
// each access completes. Optional last-read buffer: define DMC_LAST_READ_BUF_EN.
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  stall,
  output logic                  busError,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  dmcState_e state, nextState;

  logic                  request;
  logic                  aligned;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic                  startAccess;
  logic                  flagMisaligned;
  logic                  finishAck;
  logic                  finishTimeout;
  logic                  timeoutTerminal;

  assign request  = memRead | memWrite;
  assign aligned  = (addr[1:0] == 2'b00);
  assign wordAddr = {addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef DMC_LAST_READ_BUF_EN
  logic                  bufValid;
  logic [ADDR_WIDTH-3:0] bufTag;
  logic [DATA_WIDTH-1:0] bufData;
  logic                  bufHit;
  logic                  bufServe;

  assign bufHit = memRead & ~memWrite & bufValid & (bufTag == addr[ADDR_WIDTH-1:2]);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    nextState      = state;
    stall          = 1'b0;
    startAccess    = 1'b0;
    flagMisaligned = 1'b0;
    finishAck      = 1'b0;
    finishTimeout  = 1'b0;
`ifdef DMC_LAST_READ_BUF_EN
    bufServe       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (request) begin
          if (!aligned) begin
            stall          = 1'b1;
            flagMisaligned = 1'b1;
            nextState      = DONE;
          end
`ifdef DMC_LAST_READ_BUF_EN
          else if (bufHit) begin
            bufServe = 1'b1;
          end
`endif
          else begin
            stall       = 1'b1;
            startAccess = 1'b1;
            nextState   = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          finishAck = 1'b1;
          nextState = DONE;
        end else if (timeoutTerminal) begin
          finishTimeout = 1'b1;
          nextState     = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // The pipeline must not see a freeze while the controller is being reset.
    if (reset) begin
      stall = 1'b0;
    end
  end

  dmc_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != WAIT),
    .enable  ((state == WAIT) & ~mem_ack),
    .terminal(timeoutTerminal)
  );

  // mem_we doubles as the read/write tag of the access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      readData   <= '0;
      busError   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      busError   <= 1'b0;
      misaligned <= 1'b0;
      if (startAccess) begin
        mem_req   <= 1'b1;
        mem_we    <= memWrite;
        mem_addr  <= wordAddr;
        mem_wdata <= writeData;
      end
      if (finishAck) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (!mem_we) begin
          readData <= mem_rdata;
        end
      end
      if (finishTimeout) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        busError <= 1'b1;
        if (!mem_we) begin
          readData <= DATA_WIDTH'(BUS_ERROR_WORD);
        end
      end
      if (flagMisaligned) begin
        misaligned <= 1'b1;
      end
`ifdef DMC_LAST_READ_BUF_EN
      if (bufServe) begin
        readData <= bufData;
      end
`endif
    end
  end

`ifdef DMC_LAST_READ_BUF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bufValid <= 1'b0;
    end else if (finishTimeout || flagMisaligned) begin
      bufValid <= 1'b0;
    end else if (finishAck && !mem_we) begin
      bufValid <= 1'b1;
    end
  end

  // NOTE: tag and data are not reset; bufValid alone qualifies them, so the storage needs no reset network.
  always_ff @(posedge clk) begin
    if (finishAck) begin
      if (!mem_we) begin
        bufTag  <= mem_addr[ADDR_WIDTH-1:2];
        bufData <= mem_rdata;
      end else if (bufValid && (bufTag == mem_addr[ADDR_WIDTH-1:2])) begin
        bufData <= mem_wdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench for data_memory_controller: transaction-level model of the
// pipeline/memory contract, per-cycle output comparison, directed and random accesses.
module tb_data_memory_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [31:0] addr, writeData;
  logic [31:0] readData;
  logic        stall, busError, misaligned;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  data_memory_controller #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .stall     (stall),
    .busError  (busError),
    .misaligned(misaligned),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the stimulus thread.
  logic        checkEn = 1'b0;
  logic        expStall, expReq, expWe, expBusErr, expMis;
  logic [31:0] expAddr, expWdata, expRead;

  // Output-activity tallies used by the directed literal checks.
  int stallCnt = 0, reqCnt = 0, busCnt = 0, misCnt = 0;

  // External memory contents as seen by completed writes.
  logic [31:0] extMem [logic [31:0]];

`ifdef DMC_LAST_READ_BUF_EN
  logic        mbValid = 1'b0;
  logic [31:0] mbAddr, mbData;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memLookup(input logic [31:0] wa);
    return extMem.exists(wa) ? extMem[wa] : (wa ^ 32'hA5C3_0000);
  endfunction

  task automatic compareOutputs();
    check("stall",      32'(stall),      32'(expStall));
    check("mem_req",    32'(mem_req),    32'(expReq));
    check("mem_we",     32'(mem_we),     32'(expWe));
    check("busError",   32'(busError),   32'(expBusErr));
    check("misaligned", 32'(misaligned), 32'(expMis));
    check("readData",   readData,        expRead);
    if (expReq) begin
      check("mem_addr", mem_addr, expAddr);
      if (expWe) check("mem_wdata", mem_wdata, expWdata);
    end
    stallCnt += int'(stall);
    reqCnt   += int'(mem_req);
    busCnt   += int'(busError);
    misCnt   += int'(misaligned);
  endtask

  // Compare on the falling edge, then return just after the next rising edge.
  task automatic nextCycle();
    @(negedge clk);
    if (checkEn) compareOutputs();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addr      = $urandom;
    writeData = $urandom;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    expStall  = 1'b0;
    expReq    = 1'b0;
    expWe     = 1'b0;
    expBusErr = 1'b0;
    expMis    = 1'b0;
    nextCycle();
  endtask

  // One MEM-stage instruction held until the pipeline advances.
  // ackAt: WAIT cycle (1-based) carrying mem_ack; ackAt > TO means no ack at all.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int ackAt);
    logic        isWr, isRd;
    logic [31:0] wa;
    int          waits;
    isWr = wr;
    isRd = rd & ~wr;
    wa   = {a[31:2], 2'b00};
    memRead   = rd;
    memWrite  = wr;
    addr      = a;
    writeData = wd;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    expStall  = 1'b1;
    expReq    = 1'b0;
    expWe     = 1'b0;
    expBusErr = 1'b0;
    expMis    = 1'b0;
`ifdef DMC_LAST_READ_BUF_EN
    if (isRd && a[1:0] == 2'b00 && mbValid && mbAddr == wa) begin
      expStall = 1'b0;
      nextCycle();
      expRead = mbData;
      return;
    end
`endif
    if (a[1:0] != 2'b00) begin
      nextCycle();
      expStall  = 1'b0;
      expMis    = 1'b1;
      mem_ack   = 1'($urandom_range(0, 1));
`ifdef DMC_LAST_READ_BUF_EN
      mbValid = 1'b0;
`endif
    end else begin
      waits = (ackAt <= TO) ? ackAt : TO;
      for (int k = 1; k <= waits; k++) begin
        nextCycle();
        expStall  = 1'b1;
        expReq    = 1'b1;
        expWe     = isWr;
        expAddr   = wa;
        expWdata  = wd;
        mem_ack   = (k == ackAt);
        mem_rdata = (k == ackAt) ? memLookup(wa) : $urandom;
      end
      nextCycle();
      expStall  = 1'b0;
      expReq    = 1'b0;
      expWe     = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (ackAt > TO) begin
        expBusErr = 1'b1;
        if (isRd) expRead = 32'hDEADBEEF;
`ifdef DMC_LAST_READ_BUF_EN
        mbValid = 1'b0;
`endif
      end else if (isRd) begin
        expRead = memLookup(wa);
`ifdef DMC_LAST_READ_BUF_EN
        mbValid = 1'b1;
        mbAddr  = wa;
        mbData  = expRead;
`endif
      end else begin
        extMem[wa] = wd;
`ifdef DMC_LAST_READ_BUF_EN
        if (mbValid && mbAddr == wa) mbData = wd;
`endif
      end
    end
    nextCycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, r0, b0, m0;
    logic rd, wr;
    logic [31:0] a;
    int op;

    // Reset with a request already showing: outputs cleared, stall forced low.
    reset     = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b0;
    addr      = 32'h40;
    writeData = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    @(posedge clk);
    #1;
    expStall  = 1'b0;
    expReq    = 1'b0;
    expWe     = 1'b0;
    expBusErr = 1'b0;
    expMis    = 1'b0;
    expRead   = 32'h0;
    expAddr   = 32'h0;
    expWdata  = 32'h0;
    checkEn   = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    idle();

    // Write, ack in the first WAIT cycle.
    s0 = stallCnt; r0 = reqCnt;
    access(1'b0, 1'b1, 32'h40, 32'h12345678, 1);
    check("tp_write_stall_cycles", 32'(stallCnt - s0), 32'd2);
    check("tp_write_req_cycles",   32'(reqCnt - r0),   32'd1);
    check("tp_write_readData",     readData,           32'h0);

    // Read back, ack in the third WAIT cycle.
    s0 = stallCnt;
    access(1'b1, 1'b0, 32'h40, 32'h0, 3);
    check("tp_read_stall_cycles", 32'(stallCnt - s0), 32'd4);
    check("tp_read_readData",     readData,           32'h12345678);

    // Misaligned read.
    s0 = stallCnt; r0 = reqCnt; m0 = misCnt;
    access(1'b1, 1'b0, 32'h42, 32'h0, 1);
    check("tp_mis_stall_cycles", 32'(stallCnt - s0), 32'd1);
    check("tp_mis_req_cycles",   32'(reqCnt - r0),   32'd0);
    check("tp_mis_pulses",       32'(misCnt - m0),   32'd1);
    check("tp_mis_readData",     readData,           32'h12345678);

    // Read that never gets an ack.
    r0 = reqCnt; b0 = busCnt;
    access(1'b1, 1'b0, 32'h44, 32'h0, TO + 1);
    check("tp_to_req_cycles", 32'(reqCnt - r0), 32'd4);
    check("tp_to_pulses",     32'(busCnt - b0), 32'd1);
    check("tp_to_readData",   readData,         32'hDEADBEEF);

    // Ack in the very WAIT cycle that would otherwise time out.
    extMem[32'h50] = 32'h0F1E2D3C;
    b0 = busCnt;
    access(1'b1, 1'b0, 32'h50, 32'h0, TO);
    check("tp_lastack_pulses",   32'(busCnt - b0), 32'd0);
    check("tp_lastack_readData", readData,         32'h0F1E2D3C);

    // Reset in the second WAIT cycle, late ack afterwards.
    memRead = 1'b1; memWrite = 1'b0; addr = 32'h48; writeData = 32'h0; mem_ack = 1'b0;
    expStall = 1'b1; expReq = 1'b0; expWe = 1'b0; expBusErr = 1'b0; expMis = 1'b0;
    nextCycle();
    expReq = 1'b1; expAddr = 32'h48;
    nextCycle();
    reset = 1'b1;
    expStall = 1'b0;
    nextCycle();
    reset     = 1'b0;
    memRead   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    expReq    = 1'b0;
    expRead   = 32'h0;
`ifdef DMC_LAST_READ_BUF_EN
    mbValid = 1'b0;
`endif
    nextCycle();
    mem_ack = 1'b0;
    nextCycle();
    check("tp_rst_mem_req",  32'(mem_req), 32'd0);
    check("tp_rst_readData", readData,     32'h0);

`ifdef DMC_LAST_READ_BUF_EN
    extMem[32'h80] = 32'hCAFEF00D;
    access(1'b1, 1'b0, 32'h80, 32'h0, 1);
    s0 = stallCnt; r0 = reqCnt;
    access(1'b1, 1'b0, 32'h80, 32'h0, 1);
    check("tp_buf_stall_cycles", 32'(stallCnt - s0), 32'd0);
    check("tp_buf_req_cycles",   32'(reqCnt - r0),   32'd0);
    check("tp_buf_readData",     readData,           32'hCAFEF00D);
`endif

    // Random back-to-back traffic.
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      rd = (op < 5) || (op == 9);
      wr = (op >= 5);
      a  = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(rd, wr, a, $urandom, $urandom_range(1, TO + 1));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
